// File: rtl/seq_pkg.sv
// Shared types and constants for the SimpleProcessor datapath sequencer.
package seq_pkg;

  // Default datapath geometry
  localparam int unsigned DEF_NREG = 8;
  localparam int unsigned DEF_IW   = 9;
  localparam int unsigned IDXW     = 3;
  localparam int unsigned NSTEP    = 4;

  // Instruction field positions: op[8:6], rx[5:3], ry[2:0]
  localparam int unsigned OP_MSB = DEF_IW - 1;
  localparam int unsigned RX_LSB = DEF_IW - 6;
  localparam int unsigned RY_LSB = 0;

  // Bit index of each step within the one-hot step vector
  localparam int unsigned T0 = 0;
  localparam int unsigned T1 = 1;
  localparam int unsigned T2 = 2;
  localparam int unsigned T3 = 3;

  typedef enum logic [2:0] {
    OP_MV  = 3'd0,
    OP_MVI = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3
  } op_e;

  // One-hot step encoding; all-zero is the trap HALT state
  typedef enum logic [NSTEP-1:0] {
    ST_HALT = 4'b0000,
    ST_T0   = 4'(1 << T0),
    ST_T1   = 4'(1 << T1),
    ST_T2   = 4'(1 << T2),
    ST_T3   = 4'(1 << T3)
  } step_e;

  // Opcodes 4..7 are not defined
  function automatic logic op_legal(input logic [IDXW-1:0] op);
    return ~op[IDXW-1];
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register index to one-hot select, all-zero when disabled.
module reg_select_decoder
  import seq_pkg::*;
#(
  parameter int unsigned NREG = DEF_NREG
) (
  input  logic [IDXW-1:0] idx_i,
  input  logic            en_i,
  output logic [NREG-1:0] onehot_o
);

  // Indices beyond NREG simply select nothing
  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      onehot_o[i] = en_i && (idx_i == IDXW'(i));
    end
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM for the SimpleProcessor shared-bus datapath.
// Build option: SEQ_ILLEGAL_TRAP_EN turns illegal opcodes into a sticky
// HALT (step = 0000, illegal = 1) instead of a 2-cycle NOP.
module datapath_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NREG = DEF_NREG,
  parameter int unsigned IW   = DEF_IW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [IW-1:0]    instr,
  output logic             ir_in,
  output logic [NREG-1:0]  r_in,
  output logic [NREG-1:0]  r_out,
  output logic             din_out,
  output logic             a_in,
  output logic             g_in,
  output logic             g_out,
  output logic             add_sub,
  output logic             done,
  output logic [NSTEP-1:0] step,
  output logic             illegal
);

`ifdef SEQ_ILLEGAL_TRAP_EN
  localparam logic DONE_ON_ILLEGAL = 1'b0;
`else
  localparam logic DONE_ON_ILLEGAL = 1'b1;
`endif

  step_e           step_q;
  logic [IW-1:0]   ir_q;
  logic [IDXW-1:0] op;
  logic [IDXW-1:0] rx;
  logic [IDXW-1:0] ry;

  logic            r_in_en;
  logic            r_out_en;
  logic [IDXW-1:0] r_out_idx;

  assign op = ir_q[OP_MSB -: IDXW];
  assign rx = ir_q[RX_LSB +: IDXW];
  assign ry = ir_q[RY_LSB +: IDXW];

`ifdef SEQ_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky trap flag, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (step_q == ST_T1 && !op_legal(op)) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Step sequencing and instruction capture; unreachable codes recover to T0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_q <= ST_T0;
      ir_q   <= '0;
    end else begin
      case (step_q)
        ST_T0: begin
          if (run) begin
            ir_q   <= instr;
            step_q <= ST_T1;
          end
        end
        ST_T1: begin
          if (!op_legal(op)) begin
`ifdef SEQ_ILLEGAL_TRAP_EN
            step_q <= ST_HALT;
`else
            step_q <= ST_T0;
`endif
          end else if (op == OP_ADD || op == OP_SUB) begin
            step_q <= ST_T2;
          end else begin
            step_q <= ST_T0;
          end
        end
        ST_T2:   step_q <= ST_T3;
        ST_T3:   step_q <= ST_T0;
`ifdef SEQ_ILLEGAL_TRAP_EN
        ST_HALT: step_q <= ST_HALT;
`endif
        default: step_q <= ST_T0;
      endcase
    end
  end

  // Control strobes decoded from the current step and IR
  always_comb begin
    ir_in     = 1'b0;
    din_out   = 1'b0;
    a_in      = 1'b0;
    g_in      = 1'b0;
    g_out     = 1'b0;
    add_sub   = 1'b0;
    done      = 1'b0;
    r_in_en   = 1'b0;
    r_out_en  = 1'b0;
    r_out_idx = ry;
    case (step_q)
      ST_T0: begin
        // Held low during reset so nothing strobes while aborting
        ir_in = run & ~reset;
      end
      ST_T1: begin
        case (op)
          OP_MV: begin
            r_out_en = 1'b1;
            r_in_en  = 1'b1;
            done     = 1'b1;
          end
          OP_MVI: begin
            din_out = 1'b1;
            r_in_en = 1'b1;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            r_out_en  = 1'b1;
            r_out_idx = rx;
            a_in      = 1'b1;
          end
          default: done = DONE_ON_ILLEGAL;
        endcase
      end
      ST_T2: begin
        r_out_en = 1'b1;
        g_in     = 1'b1;
        add_sub  = (op == OP_SUB);
      end
      ST_T3: begin
        g_out   = 1'b1;
        r_in_en = 1'b1;
        done    = 1'b1;
      end
      default: ;
    endcase
  end

  // Destination register write enable (always rx)
  reg_select_decoder #(.NREG(NREG)) u_r_in_dec (
    .idx_i    (rx),
    .en_i     (r_in_en),
    .onehot_o (r_in)
  );

  // Register-to-bus source select
  reg_select_decoder #(.NREG(NREG)) u_r_out_dec (
    .idx_i    (r_out_idx),
    .en_i     (r_out_en),
    .onehot_o (r_out)
  );

  assign step = NSTEP'(step_q);

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with hand-computed control vectors.
module tb_datapath_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run   = 1'b0;
  logic [8:0] instr = '0;

  logic       ir_in;
  logic [7:0] r_in;
  logic [7:0] r_out;
  logic       din_out;
  logic       a_in;
  logic       g_in;
  logic       g_out;
  logic       add_sub;
  logic       done;
  logic [3:0] step;
  logic       illegal;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [8:0] I_MV_R3_R5  = 9'b000_011_101;
  localparam logic [8:0] I_SUB_R1_R2 = 9'b011_001_010;
  localparam logic [8:0] I_MVI_R0    = 9'b001_000_000;
  localparam logic [8:0] I_ADD_R0_R0 = 9'b010_000_000;
  localparam logic [8:0] I_ADD_R2_R3 = 9'b010_010_011;
  localparam logic [8:0] I_MV_R7_R2  = 9'b000_111_010;
  localparam logic [8:0] I_OP6       = 9'b110_001_001;

  datapath_sequencer dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .instr   (instr),
    .ir_in   (ir_in),
    .r_in    (r_in),
    .r_out   (r_out),
    .din_out (din_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .g_out   (g_out),
    .add_sub (add_sub),
    .done    (done),
    .step    (step),
    .illegal (illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare step and the full control-strobe vector in one go
  task automatic expect_ctl(input string tag, input logic [3:0] st, input logic ii,
                            input logic [7:0] ri, input logic [7:0] ro, input logic din,
                            input logic a, input logic gi, input logic go,
                            input logic as, input logic dn);
    check({tag, ".step"}, 32'(step), 32'(st));
    check({tag, ".ctl"},
          32'({ir_in, r_in, r_out, din_out, a_in, g_in, g_out, add_sub, done}),
          32'({ii, ri, ro, din, a, gi, go, as, dn}));
  endtask

  // Drive inputs just after the falling edge, then let outputs settle
  task automatic cyc(input logic r, input logic [8:0] i);
    @(negedge clock);
    run   = r;
    instr = i;
    #1;
  endtask

  // Shared-bus source exclusivity every cycle
  always @(negedge clock) begin
    check("bus_excl", ($countones({r_out, din_out, g_out}) <= 1) ? 32'd1 : 32'd0, 32'd1);
  end

  initial begin
    // Reset held three cycles, run low
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 9'h000);
      expect_ctl("rst", 4'b0001, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    end
    check("rst.illegal", 32'(illegal), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      expect_ctl("idle", 4'b0001, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
      cyc(1'b0, 9'h000);
    end

    // MV r3,r5
    cyc(1'b1, I_MV_R3_R5);
    expect_ctl("mv.t0", 4'b0001, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 9'h000);
    expect_ctl("mv.t1", 4'b0010, 0, 8'h08, 8'h20, 0, 0, 0, 0, 0, 1);
    cyc(1'b0, 9'h000);
    expect_ctl("mv.end", 4'b0001, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);

    // SUB r1,r2 with run toggled mid-instruction (ignored)
    cyc(1'b1, I_SUB_R1_R2);
    expect_ctl("sub.t0", 4'b0001, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, I_MV_R3_R5);
    expect_ctl("sub.t1", 4'b0010, 0, 8'h00, 8'h02, 0, 1, 0, 0, 0, 0);
    cyc(1'b1, I_MV_R3_R5);
    expect_ctl("sub.t2", 4'b0100, 0, 8'h00, 8'h04, 0, 0, 1, 0, 1, 0);
    cyc(1'b0, 9'h000);
    expect_ctl("sub.t3", 4'b1000, 0, 8'h02, 8'h00, 0, 0, 0, 1, 0, 1);
    cyc(1'b0, 9'h000);
    expect_ctl("sub.end", 4'b0001, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);

    // Back-to-back MVI r0 then ADD r0,r0, run held high
    cyc(1'b1, I_MVI_R0);
    expect_ctl("b2b.mvi.t0", 4'b0001, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, I_ADD_R0_R0);
    expect_ctl("b2b.mvi.t1", 4'b0010, 0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1);
    cyc(1'b1, I_ADD_R0_R0);
    expect_ctl("b2b.add.t0", 4'b0001, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, I_ADD_R0_R0);
    expect_ctl("b2b.add.t1", 4'b0010, 0, 8'h00, 8'h01, 0, 1, 0, 0, 0, 0);
    cyc(1'b1, I_ADD_R0_R0);
    expect_ctl("b2b.add.t2", 4'b0100, 0, 8'h00, 8'h01, 0, 0, 1, 0, 0, 0);
    cyc(1'b0, 9'h000);
    expect_ctl("b2b.add.t3", 4'b1000, 0, 8'h01, 8'h00, 0, 0, 0, 1, 0, 1);
    cyc(1'b0, 9'h000);
    expect_ctl("b2b.end", 4'b0001, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);

    // ADD r2,r3 aborted by reset in T2
    cyc(1'b1, I_ADD_R2_R3);
    expect_ctl("abort.t0", 4'b0001, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 9'h000);
    expect_ctl("abort.t1", 4'b0010, 0, 8'h00, 8'h04, 0, 1, 0, 0, 0, 0);
    cyc(1'b0, 9'h000);
    expect_ctl("abort.t2", 4'b0100, 0, 8'h00, 8'h08, 0, 0, 1, 0, 0, 0);
    run   = 1'b1;
    reset = 1'b1;
    #1;
    expect_ctl("abort.rst", 4'b0001, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    run   = 1'b0;
    reset = 1'b0;
    #1;
    expect_ctl("abort.idle", 4'b0001, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    cyc(1'b1, I_MV_R7_R2);
    expect_ctl("post.t0", 4'b0001, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 9'h000);
    expect_ctl("post.t1", 4'b0010, 0, 8'h80, 8'h04, 0, 0, 0, 0, 0, 1);
    cyc(1'b0, 9'h000);
    expect_ctl("post.end", 4'b0001, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);

    // Illegal opcode 6
    cyc(1'b1, I_OP6);
    expect_ctl("ill.t0", 4'b0001, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
`ifdef SEQ_ILLEGAL_TRAP_EN
    cyc(1'b1, I_MV_R3_R5);
    expect_ctl("ill.t1", 4'b0010, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, I_MV_R3_R5);
      expect_ctl("ill.halt", 4'b0000, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
      check("ill.halt.illegal", 32'(illegal), 32'd1);
    end
    reset = 1'b1;
    #1;
    check("ill.rst.illegal", 32'(illegal), 32'd0);
    expect_ctl("ill.rst", 4'b0001, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    run   = 1'b0;
    reset = 1'b0;
    #1;
`else
    cyc(1'b0, 9'h000);
    expect_ctl("ill.t1", 4'b0010, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
    check("ill.t1.illegal", 32'(illegal), 32'd0);
    cyc(1'b0, 9'h000);
    check("ill.end.illegal", 32'(illegal), 32'd0);
`endif
    expect_ctl("ill.end", 4'b0001, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
